clk_count_min_sec: RTL and testbench

Timebase and seconds/minutes counter that sits directly upstream of the 12-hour counter. It divides the system clock down to a 1 Hz tick, counts seconds 0-59 and minutes 0-59, and emits the single-cycle count_up_hr pulse that the hour counter consumes on each minute rollover. A manual minute-adjust input is provided for time setting while the clock is stopped.

---
 rtl/clk_pkg.sv | 7 +
 rtl/clk_mod_counter.sv | 30 +++
 rtl/clk_count_min_sec.sv | 67 ++++++
 tb/tb_clk_count_min_sec.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants for the clock counter chain (seconds, minutes, 12-hour).
package clk_pkg;
   localparam int SEC_MAX           = 59;
   localparam int MIN_MAX           = 59;
   localparam int HR12_MAX          = 11;
   localparam int TICKS_PER_SEC_DEF = 50_000_000;
endpackage

// File: rtl/clk_mod_counter.sv
// Modulo-(MAX+1) counter with a registered wrap pulse that is high in the
// same cycle the wrapped value of zero first becomes visible.
module clk_mod_counter #(
   parameter int MAX = 59
) (
   input  logic       CLK,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] value,
   output logic       wrap
);

   always_ff @(posedge CLK) begin
      if (clr) begin
         value <= 8'd0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (inc) begin
            if (value == 8'(MAX)) begin
               value <= 8'd0;
               wrap  <= 1'b1;
            end else begin
               value <= value + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/clk_count_min_sec.sv
// 1 Hz timebase plus seconds/minutes counters; emits count_up_hr to the hour
// counter on each 59:59 -> 00:00 rollover.
module clk_count_min_sec
   import clk_pkg::*;
#(
   parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
   parameter int PRESC_W       = 26
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       rst_counters,
   input  logic       run,
   input  logic       adj_min,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic       sec_tick,
   output logic       count_up_hr
);

   logic [PRESC_W-1:0] presc;
   logic               clr;
   logic               sec_elapse;
   logic               sec_carry;
   logic               adj_ok;
   logic               min_inc;
   logic               sec_wrap;
   logic               min_wrap;

   assign clr        = rst | rst_counters;
   assign sec_elapse = run & (presc == PRESC_W'(TICKS_PER_SEC - 1));
   assign sec_carry  = sec_elapse & (sec == 8'(SEC_MAX));
   assign adj_ok     = adj_min & ~run;
   assign min_inc    = sec_carry | adj_ok;

   always_ff @(posedge CLK) begin
      if (clr) begin
         presc    <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= sec_elapse;
         if (run) begin
            presc <= sec_elapse ? '0 : presc + PRESC_W'(1);
         end
      end
   end

   clk_mod_counter #(.MAX(SEC_MAX)) u_sec (
      .CLK   (CLK),
      .clr   (clr),
      .inc   (sec_elapse),
      .value (sec),
      .wrap  (sec_wrap)
   );

   clk_mod_counter #(.MAX(MIN_MAX)) u_min (
      .CLK   (CLK),
      .clr   (clr),
      .inc   (min_inc),
      .value (min),
      .wrap  (min_wrap)
   );

   // Adjust wraps can only happen with run=0, when sec never wraps, so the
   // coincidence of both wrap flops isolates the true carry rollover.
   assign count_up_hr = sec_wrap & min_wrap;

endmodule

// File: tb/tb_clk_count_min_sec.sv
// Self-checking bench for clk_count_min_sec with TICKS_PER_SEC=4.
module tb_clk_count_min_sec;
   import clk_pkg::*;

   localparam int T  = 4;
   localparam int PW = 2;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       rst_counters = 1'b0;
   logic       run = 1'b0;
   logic       adj_min = 1'b0;
   logic [7:0] sec;
   logic [7:0] min;
   logic       sec_tick;
   logic       count_up_hr;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: elapsed seconds since clear plus manual minute offset
   int m_presc = 0;
   int m_secs  = 0;
   int m_adj   = 0;
   int m_tick  = 0;
   int m_hr    = 0;
   int hr_m    = 0;

   clk_count_min_sec #(.TICKS_PER_SEC(T), .PRESC_W(PW)) dut (
      .CLK          (CLK),
      .rst          (rst),
      .rst_counters (rst_counters),
      .run          (run),
      .adj_min      (adj_min),
      .sec          (sec),
      .min          (min),
      .sec_tick     (sec_tick),
      .count_up_hr  (count_up_hr)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic r;
      logic rc;
      logic ru;
      logic adj;
      int   e_sec;
      int   e_min;
      int   e_tick;
      int   e_hr;
   } vec_t;

   vec_t vecs[$];

   function automatic int model_min();
      return ((m_secs / 60) + m_adj) % 60;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (rst || rst_counters) begin
         m_presc = 0; m_secs = 0; m_adj = 0; m_tick = 0; m_hr = 0;
      end else begin
         m_tick = 0;
         m_hr   = 0;
         if (run) begin
            if (m_presc == T - 1) begin
               m_presc = 0;
               m_secs++;
               m_tick = 1;
               if ((m_secs % 60) == 0 && model_min() == 0) m_hr = 1;
            end else begin
               m_presc++;
            end
         end else if (adj_min) begin
            m_adj++;
         end
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      if (count_up_hr === 1'b1) hr_m = (hr_m == HR12_MAX) ? 0 : hr_m + 1;
      chk("sec",         {24'd0, sec},          32'(m_secs % 60));
      chk("min",         {24'd0, min},          32'(model_min()));
      chk("sec_tick",    {31'd0, sec_tick},     32'(m_tick));
      chk("count_up_hr", {31'd0, count_up_hr},  32'(m_hr));
   endtask

   task automatic clear_counters();
      rst_counters = 1'b1;
      step();
      rst_counters = 1'b0;
   endtask

   // waits for a sec_tick with run=1, returns the number of cycles taken
   task automatic cycles_to_tick(input string name, output int n);
      n = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (sec_tick === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic reach_17_2();
      run = 1'b1;
      clear_counters();
      repeat (17 * T + 2) step();
      chk("pre_sec17", {24'd0, sec}, 32'd17);
   endtask

   initial begin
      int n;
      int run_cycles;
      int saw_bad;

      // reset held with run/adj asserted, then 12 cycles of counting
      for (int i = 0; i < 2; i++) vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0});
      for (int k = 1; k <= 12; k++)
         vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, k / T, 0, (k % T == 0) ? 1 : 0, 0});

      foreach (vecs[i]) begin
         rst = vecs[i].r; rst_counters = vecs[i].rc; run = vecs[i].ru; adj_min = vecs[i].adj;
         step();
         chk("vec_sec",  {24'd0, sec},         32'(vecs[i].e_sec));
         chk("vec_min",  {24'd0, min},         32'(vecs[i].e_min));
         chk("vec_tick", {31'd0, sec_tick},    32'(vecs[i].e_tick));
         chk("vec_hr",   {31'd0, count_up_hr}, 32'(vecs[i].e_hr));
      end

      // one full hour from clear
      run = 1'b1;
      clear_counters();
      repeat (3599 * T) step();
      chk("hour_sec59", {24'd0, sec}, 32'd59);
      chk("hour_min59", {24'd0, min}, 32'd59);
      repeat (T - 1) step();
      chk("hour_no_early_hr", {31'd0, count_up_hr}, 32'd0);
      step();
      chk("roll_sec0",  {24'd0, sec},         32'd0);
      chk("roll_min0",  {24'd0, min},         32'd0);
      chk("roll_hr",    {31'd0, count_up_hr}, 32'd1);
      chk("roll_tick",  {31'd0, sec_tick},    32'd1);
      chk("hr_model",   32'(hr_m),            32'd1);
      step();
      chk("roll_hr_one_cycle", {31'd0, count_up_hr}, 32'd0);

      // minute adjust while stopped
      clear_counters();
      repeat (17 * T) step();
      run = 1'b0; adj_min = 1'b1;
      saw_bad = 0;
      repeat (61) begin
         step();
         if (count_up_hr !== 1'b0 || sec_tick !== 1'b0) saw_bad = 1;
      end
      adj_min = 1'b0;
      chk("adj_min1",     {24'd0, min}, 32'd1);
      chk("adj_sec17",    {24'd0, sec}, 32'd17);
      chk("adj_no_pulse", 32'(saw_bad), 32'd0);

      // mid-second clears via rst_counters and rst
      reach_17_2();
      clear_counters();
      chk("rc_sec0", {24'd0, sec}, 32'd0);
      chk("rc_min0", {24'd0, min}, 32'd0);
      cycles_to_tick("rc_tick", n);
      chk("rc_tick_latency", 32'(n), 32'(T));
      reach_17_2();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_sec0", {24'd0, sec}, 32'd0);
      chk("rst_min0", {24'd0, min}, 32'd0);
      cycles_to_tick("rst_tick", n);
      chk("rst_tick_latency", 32'(n), 32'(T));

      // adj ignored while running; freeze mid-second
      run = 1'b0; clear_counters();
      adj_min = 1'b1;
      repeat (10) step();
      adj_min = 1'b0;
      chk("set_min10", {24'd0, min}, 32'd10);
      run = 1'b1; adj_min = 1'b1;
      step();
      adj_min = 1'b0;
      chk("run_adj_ignored", {24'd0, min}, 32'd10);
      cycles_to_tick("sync_tick", n);
      run_cycles = 2;
      repeat (2) step();
      run = 1'b0;
      repeat (3) step();
      run = 1'b1;
      cycles_to_tick("resume_tick", n);
      run_cycles += n;
      chk("resume_period", 32'(run_cycles), 32'(T));

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         run          = ($urandom_range(0, 3) != 0);
         adj_min      = ($urandom_range(0, 3) == 0);
         rst_counters = ($urandom_range(0, 299) == 0);
         step();
      end
      rst_counters = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
